// File: rtl/fft_control_param_if.sv
// Handshake and address bus of the radix-4 FFT address/sequencing controller.
// The controller takes the master view. The datapath or bench takes the slave view.
interface fft_control_param_if #(
  parameter int LOG2_NMAX = 10
);
  logic                 iSTART;
  logic                 iABORT;
  logic                 iINV;
  logic [2:0]           iLOG4_SIZE;

  logic [LOG2_NMAX-1:0] oADDR_RD_0;
  logic [LOG2_NMAX-1:0] oADDR_RD_1;
  logic [LOG2_NMAX-1:0] oADDR_RD_2;
  logic [LOG2_NMAX-1:0] oADDR_RD_3;
  logic                 oRD_EN;
  logic [LOG2_NMAX-1:0] oADDR_WR_0;
  logic [LOG2_NMAX-1:0] oADDR_WR_1;
  logic [LOG2_NMAX-1:0] oADDR_WR_2;
  logic [LOG2_NMAX-1:0] oADDR_WR_3;
  logic                 oWR_EN;
  logic [LOG2_NMAX-3:0] oADDR_COEF;
  logic [2:0]           oSTAGE;
  logic                 oINV;
  logic                 oBUSY;
  logic                 oRDY;

  modport master (
    input  iSTART, iABORT, iINV, iLOG4_SIZE,
    output oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3, oRD_EN,
    output oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3, oWR_EN,
    output oADDR_COEF, oSTAGE, oINV, oBUSY, oRDY
  );

  modport slave (
    output iSTART, iABORT, iINV, iLOG4_SIZE,
    input  oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3, oRD_EN,
    input  oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3, oWR_EN,
    input  oADDR_COEF, oSTAGE, oINV, oBUSY, oRDY
  );
endinterface

// File: rtl/fft_control_param.sv
// Radix-4 in-place FFT sequencer.
// It issues one butterfly read per cycle for each stage.
// After each stage it drains for BUT_LAT cycles so that every write of the stage lands
// before the next stage reads.
// Write addresses are the read addresses, delayed through a BUT_LAT-deep shift register.
module fft_control_param #(
  parameter int LOG2_NMAX = 10,  // even, 4..14
  parameter int BUT_LAT   = 4    // >= 1
) (
  input  logic                iCLK,
  input  logic                iRESET,
  fft_control_param_if.master bus
);
  localparam int AW = LOG2_NMAX;
  localparam int BW = LOG2_NMAX - 2;
  localparam int CW = (BUT_LAT > 1) ? $clog2(BUT_LAT) : 1;
  localparam logic [2:0] S_MAX = 3'(LOG2_NMAX / 2);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // sequencing state
  logic [1:0]    state_q, state_d;
  logic [2:0]    s_q, s_d;
  logic [BW-1:0] b_q, b_d;
  logic [2:0]    size_q, size_d;
  logic          inv_q, inv_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // registered outputs
  logic                         rd_en_q, rd_en_d;
  logic [3:0][AW-1:0]           rd_addr_q, rd_addr_d;
  logic [BW-1:0]                coef_q, coef_d;
  logic [2:0]                   stage_q, stage_d;
  logic                         inv_out_q, inv_out_d;
  logic                         busy_q, busy_d;
  logic                         rdy_q, rdy_d;
  logic [BUT_LAT-1:0]           wr_en_sr_q, wr_en_sr_d;
  logic [BUT_LAT-1:0][3:0][AW-1:0] wr_addr_sr_q, wr_addr_sr_d;

  logic          abort_act;
  logic          run_ok;
  logic [2:0]    size_clamped;
  logic [AW-1:0] last_b_val;
  logic [3:0]    two_s;
  logic [3:0]    coef_sh;
  logic [AW-1:0] b_ext;
  logic [AW-1:0] low_mask;
  logic [AW-1:0] j_val;
  logic [AW-1:0] g_part;

  // Abort only matters while a transform is in flight; it outranks everything else.
  assign abort_act = bus.iABORT && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
  assign run_ok    = (state_q == ST_RUN) && !abort_act;

  // Clamp the requested stage count into the supported 2..LOG2_NMAX/2 range.
  always_comb begin
    size_clamped = bus.iLOG4_SIZE;
    if (bus.iLOG4_SIZE < 3'd2)
      size_clamped = 3'd2;
    else if (bus.iLOG4_SIZE > S_MAX)
      size_clamped = S_MAX;
  end

  // Butterfly index decomposition. j is b mod 4^s and g is b / 4^s.
  // The read address is g, then k, then j, with the 2-bit k field inserted at bit 2s.
  always_comb begin
    two_s      = {s_q, 1'b0};
    coef_sh    = {size_q, 1'b0} - two_s - 4'd2;
    b_ext      = AW'(b_q);
    low_mask   = (AW'(1) << two_s) - AW'(1);
    j_val      = b_ext & low_mask;
    g_part     = (b_ext >> two_s) << (two_s + 4'd2);
    last_b_val = (AW'(1) << ({size_q, 1'b0} - 4'd2)) - AW'(1);
  end

  // Next-state logic: IDLE -> RUN (N/4 reads) -> DRAIN (BUT_LAT) -> next stage or DONE.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    b_d     = b_q;
    size_d  = size_q;
    inv_d   = inv_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.iSTART) begin
          size_d  = size_clamped;
          inv_d   = bus.iINV;
          s_d     = 3'd0;
          b_d     = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (b_ext == last_b_val) begin
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          b_d = b_q + BW'(1);
        end
      end
      ST_DRAIN: begin
        if (cnt_q == CW'(BUT_LAT - 1)) begin
          if (s_q == size_q - 3'd1) begin
            state_d = ST_DONE;
          end else begin
            s_d     = s_q + 3'd1;
            b_d     = '0;
            state_d = ST_RUN;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort_act)
      state_d = ST_IDLE;
  end

  // Output register inputs follow the current state, so they appear one cycle later.
  always_comb begin
    rd_en_d   = run_ok;
    coef_d    = run_ok ? BW'(j_val << coef_sh) : '0;
    stage_d   = s_q;
    inv_out_d = inv_q;
    busy_d    = !abort_act && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
    rdy_d     = (state_q == ST_DONE);
  end

  genvar gi;

  // One read address per butterfly leg.
  for (gi = 0; gi < 4; gi++) begin : g_lane
    assign rd_addr_d[gi] = run_ok ? (g_part | (AW'(gi) << two_s) | j_val) : '0;
  end

  // Write-side delay line. An abort flushes it so that no stale write escapes.
  for (gi = 0; gi < BUT_LAT; gi++) begin : g_sr
    if (gi == 0) begin : g_head
      assign wr_en_sr_d[gi]   = abort_act ? 1'b0 : rd_en_q;
      assign wr_addr_sr_d[gi] = abort_act ? '0 : rd_addr_q;
    end else begin : g_tail
      assign wr_en_sr_d[gi]   = abort_act ? 1'b0 : wr_en_sr_q[gi-1];
      assign wr_addr_sr_d[gi] = abort_act ? '0 : wr_addr_sr_q[gi-1];
    end
  end

  // Sequencing state flops.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      b_q     <= '0;
      size_q  <= '0;
      inv_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      b_q     <= b_d;
      size_q  <= size_d;
      inv_q   <= inv_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output and shift-register flops.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      coef_q       <= '0;
      stage_q      <= '0;
      inv_out_q    <= 1'b0;
      busy_q       <= 1'b0;
      rdy_q        <= 1'b0;
      wr_en_sr_q   <= '0;
      wr_addr_sr_q <= '0;
    end else begin
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      coef_q       <= coef_d;
      stage_q      <= stage_d;
      inv_out_q    <= inv_out_d;
      busy_q       <= busy_d;
      rdy_q        <= rdy_d;
      wr_en_sr_q   <= wr_en_sr_d;
      wr_addr_sr_q <= wr_addr_sr_d;
    end
  end

  assign bus.oRD_EN     = rd_en_q;
  assign bus.oADDR_RD_0 = rd_addr_q[0];
  assign bus.oADDR_RD_1 = rd_addr_q[1];
  assign bus.oADDR_RD_2 = rd_addr_q[2];
  assign bus.oADDR_RD_3 = rd_addr_q[3];
  assign bus.oWR_EN     = wr_en_sr_q[BUT_LAT-1];
  assign bus.oADDR_WR_0 = wr_addr_sr_q[BUT_LAT-1][0];
  assign bus.oADDR_WR_1 = wr_addr_sr_q[BUT_LAT-1][1];
  assign bus.oADDR_WR_2 = wr_addr_sr_q[BUT_LAT-1][2];
  assign bus.oADDR_WR_3 = wr_addr_sr_q[BUT_LAT-1][3];
  assign bus.oADDR_COEF = coef_q;
  assign bus.oSTAGE     = stage_q;
  assign bus.oINV       = inv_out_q;
  assign bus.oBUSY      = busy_q;
  assign bus.oRDY       = rdy_q;
endmodule

// File: doc/fft_control_param.md
FFT_CONTROL_PARAM -- requirements
Module: fft_control_param

Interface
REQ-001 Parameter LOG2_NMAX, default 10, meaning log2 of maximum point count; SHALL be even and in the range 4..14.
REQ-002 Parameter BUT_LAT, default 4, meaning butterfly read-to-write latency in cycles; SHALL be >= 1.
REQ-003 iCLK  in  1  meaning the single clock; all state SHALL change on its rising edge.
REQ-004 iRESET  in  1  meaning reset, asynchronous, active-low.
REQ-005 iSTART  in  1  meaning a one-cycle start pulse.
REQ-006 iABORT  in  1  meaning cancel the transform in progress.
REQ-007 iINV  in  1  meaning inverse-transform mode, sampled with iSTART.
REQ-008 iLOG4_SIZE  in  3  meaning radix-4 stage count S, with N = 4^S, sampled with iSTART.
REQ-009 oADDR_RD_0..oADDR_RD_3  out  LOG2_NMAX each  meaning the point indices of butterfly inputs 0..3.
REQ-010 oRD_EN  out  1  meaning the read addresses are valid.
REQ-011 oADDR_WR_0..oADDR_WR_3  out  LOG2_NMAX each  meaning the point indices of butterfly outputs 0..3.
REQ-012 oWR_EN  out  1  meaning the write addresses are valid.
REQ-013 oADDR_COEF  out  LOG2_NMAX-2  meaning the twiddle exponent.
REQ-014 oSTAGE  out  3  meaning the current stage index s.
REQ-015 oINV  out  1  meaning the latched inverse flag.
REQ-016 oBUSY  out  1  meaning a transform is in progress.
REQ-017 oRDY  out  1  meaning a one-cycle completion pulse.

Function
REQ-018 The block SHALL implement an FSM with states IDLE, RUN, DRAIN and DONE, and all outputs SHALL be registered.
REQ-019 In IDLE, an iSTART sampled high SHALL latch S and iINV, clear s and b, and enter RUN on that edge.
REQ-020 iSTART SHALL be ignored outside IDLE.
REQ-021 An iLOG4_SIZE outside 2..LOG2_NMAX/2 SHALL be clamped to the nearest bound.
REQ-022 In RUN, each cycle SHALL assert oRD_EN for butterfly b of stage s.
REQ-023 In RUN, the address and coefficient mapping SHALL be:
- Q = 4^s, G = 4Q, g = b / Q, j = b mod Q
- oADDR_RD_k = g*G + j + k*Q
- oADDR_COEF = j * 4^(S-1-s)
- address bits above log2 N SHALL be zero.
REQ-024 b SHALL run from 0 to N/4-1; on the final value the FSM SHALL enter DRAIN.
REQ-025 DRAIN SHALL last exactly BUT_LAT cycles with oRD_EN low, and then:
- if s = S-1, the FSM SHALL enter DONE;
- otherwise s SHALL increment, b SHALL clear, and the FSM SHALL return to RUN.
REQ-026 oWR_EN and oADDR_WR_k SHALL equal oRD_EN and oADDR_RD_k delayed by exactly BUT_LAT cycles, through a shift register.
REQ-027 Consequence of REQ-025 and REQ-026: the first read of stage s+1 SHALL occur strictly after the last write of stage s, with no gap beyond one cycle.
REQ-028 DONE SHALL last one cycle with oRDY = 1, then the FSM SHALL return to IDLE.
REQ-029 oBUSY SHALL be 1 in RUN and DRAIN, and 0 otherwise.
REQ-030 Latency from the edge sampling iSTART to oRDY high SHALL be S*(N/4 + BUT_LAT) + 1 cycles.
REQ-031 iABORT high in RUN or DRAIN SHALL, on the next edge:
- force IDLE;
- clear oRD_EN, oBUSY and the whole write shift register (oWR_EN = 0 from that edge onward);
- produce no oRDY.
REQ-032 iABORT SHALL take precedence over iSTART in the same cycle.
REQ-033 iABORT in IDLE or DONE SHALL be ignored.
REQ-034 oINV and oSTAGE SHALL hold their values through the transform; oINV SHALL hold after completion until the next start.

Reset
REQ-035 iRESET low SHALL immediately force IDLE and clear s, b, the shift register and every output to 0, regardless of the clock.
REQ-036 Release of iRESET SHALL take effect at the next iCLK edge.
REQ-037 Reset mid-transform SHALL discard all progress.

Verification
REQ-038 Scenario N=16: iLOG4_SIZE=2, BUT_LAT=4, start at edge 0 -> the bench SHALL check:
- cycles 1..4: reads (0,1,2,3), (4,5,6,7), (8,9,10,11), (12,13,14,15), coefficient 0, oSTAGE=0;
- cycles 9..12: reads (b, b+4, b+8, b+12), coefficient b, oSTAGE=1;
- oRDY high only at cycle 17.
REQ-039 Scenario write timing, same run -> oWR_EN SHALL be high at cycles 5..8 and 13..16, with write addresses equal to the reads 4 cycles earlier.
REQ-040 Scenario clamp: iLOG4_SIZE=7 with LOG2_NMAX=10 -> S SHALL be 5, N=1024, and oRDY SHALL assert at cycle 5*(256+4)+1 = 1301.
REQ-041 Scenario abort: iABORT at cycle 6 of the N=16 run -> oBUSY=0 and oWR_EN=0 from cycle 7, and oRDY SHALL never assert.
REQ-042 Scenario start while busy: iSTART pulsed at cycle 3 -> the transform SHALL be unaffected, with a single oRDY at cycle 17.
REQ-043 Scenario reset: iRESET low at cycle 10 -> all outputs SHALL be 0 immediately; after release, a new iSTART SHALL reproduce REQ-038 exactly.
